// File: rtl/ram_pkg.sv
// Shared types and elaboration-time parameter checks for the dual-port tensor RAM.
package ram_pkg;

   typedef enum logic {
      READ_FIRST  = 1'b0,
      WRITE_FIRST = 1'b1
   } rdw_mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   function automatic int unsigned nb(input int unsigned data_width, input int unsigned byte_w);
      return data_width / byte_w;
   endfunction

   function automatic bit latency_ok(input int unsigned lat);
      return (lat == 1) || (lat == 2);
   endfunction

   function automatic bit length_ok(input int unsigned len, input int unsigned aw);
      return (len >= 1) && (longint'(len) <= (longint'(1) << aw));
   endfunction

   function automatic bit width_ok(input int unsigned data_width, input int unsigned byte_w);
      return (byte_w != 0) && (data_width % byte_w == 0);
   endfunction

endpackage

// File: rtl/ram_out_pipe.sv
// Read-data/valid delay line; data holds its last value between valid pulses.
module ram_out_pipe
#(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned READ_LATENCY = 1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic                  s1_valid_q, s1_valid_d;
   logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;

   always_comb begin
      s1_valid_d = in_valid;
      s1_data_d  = in_valid ? in_data : s1_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
      end
   end

   if (READ_LATENCY >= 2) begin : g_stage2
      logic                  s2_valid_q, s2_valid_d;
      logic [DATA_WIDTH-1:0] s2_data_q,  s2_data_d;

      always_comb begin
         s2_valid_d = s1_valid_q;
         s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
         end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
         end
      end

      assign out_valid = s2_valid_q;
      assign out_data  = s2_data_q;
   end else begin : g_stage1
      assign out_valid = s1_valid_q;
      assign out_data  = s1_data_q;
   end

endmodule

// File: rtl/ram_dp_t.sv
// True dual-port RAM with byte enables, selectable read latency / read-during-write mode,
// and a clear engine that zeroes the array after reset or on request.
module ram_dp_t
   import ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned ADDR_SIZE      = 10,
   parameter int unsigned MEM_LENGTH     = 1024,
   parameter int unsigned BYTE_W         = 8,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned RDW_MODE       = 0,
   parameter int unsigned CLEAR_ON_RESET = 1
)
(
   input  logic                                clka,
   input  logic                                rsta,
   input  logic                                ena,
   input  logic [nb(DATA_WIDTH, BYTE_W)-1:0]   wea,
   input  logic [ADDR_SIZE-1:0]                addra,
   input  logic [DATA_WIDTH-1:0]               dina,
   output logic [DATA_WIDTH-1:0]               douta,
   output logic                                valida,
   input  logic                                enb,
   input  logic [nb(DATA_WIDTH, BYTE_W)-1:0]   web,
   input  logic [ADDR_SIZE-1:0]                addrb,
   input  logic [DATA_WIDTH-1:0]               dinb,
   output logic [DATA_WIDTH-1:0]               doutb,
   output logic                                validb,
   input  logic                                clear_req,
   output logic                                busy
);

   localparam int unsigned         NB        = nb(DATA_WIDTH, BYTE_W);
   localparam int unsigned         IDX_W     = (MEM_LENGTH > 1) ? $clog2(MEM_LENGTH) : 1;
   localparam bit                  LAT_OK    = latency_ok(READ_LATENCY);
   localparam bit                  LEN_OK    = length_ok(MEM_LENGTH, ADDR_SIZE);
   localparam bit                  WID_OK    = width_ok(DATA_WIDTH, BYTE_W);
   localparam rdw_mode_e           RDW       = (RDW_MODE == 1) ? WRITE_FIRST : READ_FIRST;
   localparam logic [ADDR_SIZE:0]  MEM_LEN_W = (ADDR_SIZE+1)'(MEM_LENGTH);
   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_LENGTH - 1);

   if (!LAT_OK) begin : g_bad_latency
      $error("ram_dp_t: READ_LATENCY must be 1 or 2");
   end
   if (!LEN_OK || !WID_OK) begin : g_bad_geometry
      $error("ram_dp_t: MEM_LENGTH/DATA_WIDTH/BYTE_W out of range");
   end

   logic [DATA_WIDTH-1:0] mem [MEM_LENGTH];

   state_e                state_q, state_d;
   logic [ADDR_SIZE-1:0]  cnt_q,   cnt_d;

   logic                  acc_a, acc_b, in_a, in_b;
   logic [IDX_W-1:0]      idx_a, idx_b;
   logic [DATA_WIDTH-1:0] rd_a, rd_b;

   assign busy  = (state_q == CLEAR);
   assign acc_a = ena & ~busy & ~rsta;
   assign acc_b = enb & ~busy & ~rsta;
   assign in_a  = ({1'b0, addra} < MEM_LEN_W);
   assign in_b  = ({1'b0, addrb} < MEM_LEN_W);
   assign idx_a = addra[IDX_W-1:0];
   assign idx_b = addrb[IDX_W-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Each port sees only its own write merged in; the other port's same-cycle write is not visible.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      if (in_a) begin
         rd_a = mem[idx_a];
         if (RDW == WRITE_FIRST) begin
            for (int unsigned i = 0; i < NB; i++) begin
               if (wea[i]) rd_a[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
            end
         end
      end
      if (in_b) begin
         rd_b = mem[idx_b];
         if (RDW == WRITE_FIRST) begin
            for (int unsigned i = 0; i < NB; i++) begin
               if (web[i]) rd_b[i*BYTE_W +: BYTE_W] = dinb[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Port A lanes are assigned after port B so A wins any lane both ports write.
   always_ff @(posedge clka) begin
      if (busy) begin
         mem[cnt_q[IDX_W-1:0]] <= '0;
      end else begin
         if (acc_b && in_b) begin
            for (int unsigned i = 0; i < NB; i++) begin
               if (web[i]) mem[idx_b][i*BYTE_W +: BYTE_W] <= dinb[i*BYTE_W +: BYTE_W];
            end
         end
         if (acc_a && in_a) begin
            for (int unsigned i = 0; i < NB; i++) begin
               if (wea[i]) mem[idx_a][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   ram_out_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_pipe_a (
      .clk       (clka),
      .rst       (rsta),
      .in_valid  (acc_a),
      .in_data   (rd_a),
      .out_valid (valida),
      .out_data  (douta)
   );

   ram_out_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_pipe_b (
      .clk       (clka),
      .rst       (rsta),
      .in_valid  (acc_b),
      .in_data   (rd_b),
      .out_valid (validb),
      .out_data  (doutb)
   );

endmodule
